// File: rtl/wide_decoder_pipe.sv
// wide_decoder_pipe: pipelined N-to-2^N one-hot decoder for regfile write
// enables, with stall/flush, zero-register masking and an in-flight busy vector.
module wide_decoder_pipe #(
  parameter int ADDR_W    = 5,
  parameter int STAGES    = 2,
  parameter int MASK_ZERO = 1,
  parameter int ZERO_IDX  = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_en,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [2**ADDR_W-1:0] out_onehot,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int N = 2**ADDR_W;
  localparam bit MZ = (MASK_ZERO != 0);
  localparam logic [ADDR_W-1:0] ZI =
    ADDR_W'(ZERO_IDX);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [N-1:0]      oh;
  } stage_t;

  stage_t st [STAGES];
  stage_t cap;
  logic   live;
  logic   is_zero;

  // Qualify the input and decode it into the stage-1 image.
  always_comb begin
    is_zero = (in_addr == ZI);
    live    = in_valid & in_en & ~(MZ & is_zero);
    cap.v   = live;
    cap.a   = in_addr;
    cap.oh  = live ? (N'(1) << in_addr) : '0;
  end

  // Stage registers: flush beats stall, stall beats shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++)
        st[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        st[k].v  <= 1'b0;
        st[k].oh <= '0;
      end
    end else if (!stall) begin
      for (int k = STAGES-1; k > 0; k--)
        st[k] <= st[k-1];
      st[0] <= cap;
    end
  end

  // Pending-write vector for hazard detection, from stage state only.
  always_comb begin
    busy = '0;
    for (int k = 0; k < STAGES; k++)
      busy = busy | st[k].oh;
  end

  assign out_valid  = st[STAGES-1].v;
  assign out_addr   = st[STAGES-1].a;
  assign out_onehot = st[STAGES-1].oh;

endmodule

// File: tb/tb_wide_decoder_pipe.sv
// tb_wide_decoder_pipe: directed vectors and multi-cycle sequences for
// wide_decoder_pipe across mask and depth variants sharing one stimulus.
module tb_wide_decoder_pipe;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_en = 1'b0;
  logic [4:0] in_addr = '0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  logic m_v, n_v, s1_v, s4_v;
  logic [4:0] m_a, n_a, s1_a, s4_a;
  logic [31:0] m_oh, n_oh, s1_oh, s4_oh;
  logic [31:0] m_b, n_b, s1_b, s4_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_decoder_pipe #(.ADDR_W(5), .STAGES(2), .MASK_ZERO(1)) u_m (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_en(in_en),
    .in_addr(in_addr), .stall(stall), .flush(flush),
    .out_valid(m_v), .out_addr(m_a), .out_onehot(m_oh), .busy(m_b));

  wide_decoder_pipe #(.ADDR_W(5), .STAGES(2), .MASK_ZERO(0)) u_n (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_en(in_en),
    .in_addr(in_addr), .stall(stall), .flush(flush),
    .out_valid(n_v), .out_addr(n_a), .out_onehot(n_oh), .busy(n_b));

  wide_decoder_pipe #(.ADDR_W(5), .STAGES(1), .MASK_ZERO(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_en(in_en),
    .in_addr(in_addr), .stall(stall), .flush(flush),
    .out_valid(s1_v), .out_addr(s1_a), .out_onehot(s1_oh), .busy(s1_b));

  wide_decoder_pipe #(.ADDR_W(5), .STAGES(4), .MASK_ZERO(1)) u_s4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_en(in_en),
    .in_addr(in_addr), .stall(stall), .flush(flush),
    .out_valid(s4_v), .out_addr(s4_a), .out_onehot(s4_oh), .busy(s4_b));

  typedef struct {
    logic        v;
    logic        en;
    logic [4:0]  a;
    logic        ev;
    logic [31:0] eoh;
    logic        nv;
    logic [31:0] noh;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic v, input logic [4:0] a);
    in_valid = v;
    in_en = 1'b1;
    in_addr = a;
  endtask

  initial begin
    logic [31:0] eb;
    logic [4:0] pa;

    tbl[0] = '{1'b1, 1'b1, 5'd5,  1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020};
    tbl[1] = '{1'b1, 1'b0, 5'd5,  1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 5'd7,  1'b0, 32'h0,         1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 5'd31, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
    tbl[4] = '{1'b1, 1'b1, 5'd0,  1'b1, 32'h0000_0001, 1'b1, 32'h0000_0001};
    tbl[5] = '{1'b1, 1'b1, 5'd30, 1'b1, 32'h4000_0000, 1'b1, 32'h4000_0000};
    tbl[6] = '{1'b0, 1'b0, 5'd31, 1'b0, 32'h0,         1'b0, 32'h0};

    #2;
    chk("rst_m_valid", {63'd0, m_v}, 64'd0);
    chk("rst_m_onehot", {32'd0, m_oh}, 64'd0);
    chk("rst_m_busy", {32'd0, m_b}, 64'd0);
    chk("rst_m_addr", {59'd0, m_a}, 64'd0);
    tick();
    reset_n = 1'b1;

    // isolated vectors: each one followed by bubbles
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v;
      in_en = tbl[i].en;
      in_addr = tbl[i].a;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_s1_v", i), {63'd0, s1_v}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_s1_oh", i), {32'd0, s1_oh}, {32'd0, tbl[i].eoh});
      tick();
      chk($sformatf("vec%0d_m_v", i), {63'd0, m_v}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_m_oh", i), {32'd0, m_oh}, {32'd0, tbl[i].eoh});
      chk($sformatf("vec%0d_m_a", i), {59'd0, m_a}, {59'd0, tbl[i].a});
      chk($sformatf("vec%0d_n_v", i), {63'd0, n_v}, {63'd0, tbl[i].nv});
      chk($sformatf("vec%0d_n_oh", i), {32'd0, n_oh}, {32'd0, tbl[i].noh});
      tick();
      tick();
      chk($sformatf("vec%0d_s4_v", i), {63'd0, s4_v}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_s4_oh", i), {32'd0, s4_oh}, {32'd0, tbl[i].eoh});
    end

    // back-to-back sweep 0..31 with busy model
    for (int i = 0; i < 34; i++) begin
      if (i < 32) put(1'b1, 5'(i));
      else in_valid = 1'b0;
      tick();
      eb = '0;
      if (i < 31) eb[i] = 1'b1;
      if (i >= 1 && i <= 31) begin
        pa = 5'(i - 1);
        eb[pa] = 1'b1;
      end
      chk($sformatf("sweep%0d_busy", i), {32'd0, m_b}, {32'd0, eb});
      if (i >= 1 && i <= 32) begin
        pa = 5'(i - 1);
        if (i - 1 == 31) begin
          chk("sweep31_v", {63'd0, m_v}, 64'd0);
          chk("sweep31_oh", {32'd0, m_oh}, 64'd0);
        end else begin
          chk($sformatf("sweep%0d_v", i - 1), {63'd0, m_v}, 64'd1);
          chk($sformatf("sweep%0d_a", i - 1), {59'd0, m_a}, {59'd0, pa});
          chk($sformatf("sweep%0d_oh", i - 1), {32'd0, m_oh},
              {32'd0, 32'd1 << pa});
        end
      end
    end
    tick();

    // stall: 3 then 7, two stall cycles with input 12 presented
    put(1'b1, 5'd3);
    tick();
    put(1'b1, 5'd7);
    tick();
    chk("stall_pre_a", {59'd0, m_a}, 64'd3);
    stall = 1'b1;
    put(1'b1, 5'd12);
    tick();
    chk("stall1_v", {63'd0, m_v}, 64'd1);
    chk("stall1_oh", {32'd0, m_oh}, 64'h8);
    chk("stall1_busy", {32'd0, m_b}, 64'h88);
    tick();
    chk("stall2_a", {59'd0, m_a}, 64'd3);
    chk("stall2_oh", {32'd0, m_oh}, 64'h8);
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("stall_post7_v", {63'd0, m_v}, 64'd1);
    chk("stall_post7_oh", {32'd0, m_oh}, 64'h80);
    tick();
    chk("stall_no12_v", {63'd0, m_v}, 64'd0);
    chk("stall_no12_busy", {32'd0, m_b}, 64'd0);

    // flush with stall in the same cycle
    put(1'b1, 5'd4);
    tick();
    put(1'b1, 5'd9);
    tick();
    chk("flush_pre_oh", {32'd0, m_oh}, 64'h10);
    flush = 1'b1;
    stall = 1'b1;
    put(1'b1, 5'd20);
    tick();
    chk("flush_v", {63'd0, m_v}, 64'd0);
    chk("flush_busy", {32'd0, m_b}, 64'd0);
    chk("flush_oh", {32'd0, m_oh}, 64'd0);
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_no9_v", {63'd0, m_v}, 64'd0);
    chk("flush_no9_busy", {32'd0, m_b}, 64'd0);

    // duplicate address in flight
    put(1'b1, 5'd2);
    tick();
    chk("dup_busy1", {32'd0, m_b}, 64'h4);
    tick();
    in_valid = 1'b0;
    chk("dup_busy2", {32'd0, m_b}, 64'h4);
    tick();
    chk("dup_busy3", {32'd0, m_b}, 64'h4);
    tick();
    chk("dup_busy4", {32'd0, m_b}, 64'h0);

    // asynchronous reset mid-stream
    put(1'b1, 5'd6);
    tick();
    put(1'b1, 5'd8);
    tick();
    chk("rst_pre_v", {63'd0, m_v}, 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_m_v", {63'd0, m_v}, 64'd0);
    chk("arst_m_a", {59'd0, m_a}, 64'd0);
    chk("arst_m_busy", {32'd0, m_b}, 64'd0);
    chk("arst_s4_busy", {32'd0, s4_b}, 64'd0);
    chk("arst_s1_oh", {32'd0, s1_oh}, 64'd0);
    tick();
    reset_n = 1'b1;
    put(1'b1, 5'd11);
    tick();
    in_valid = 1'b0;
    chk("rel_s1_a", {59'd0, s1_a}, 64'd11);
    chk("rel_s1_oh", {32'd0, s1_oh}, 64'h800);
    chk("rel_m_v_early", {63'd0, m_v}, 64'd0);
    tick();
    chk("rel_m_v", {63'd0, m_v}, 64'd1);
    chk("rel_m_oh", {32'd0, m_oh}, 64'h800);
    tick();
    chk("rel_s4_v_early", {63'd0, s4_v}, 64'd0);
    tick();
    chk("rel_s4_v", {63'd0, s4_v}, 64'd1);
    chk("rel_s4_a", {59'd0, s4_a}, 64'd11);
    chk("rel_s4_oh", {32'd0, s4_oh}, 64'h800);
    tick();
    chk("rel_s4_busy_end", {32'd0, s4_b}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wide_decoder_pipe.md
# wide_decoder_pipe

Parametrised, pipelined N-to-2^N one-hot decoder that generates register-file write enables for the pipelined CPU. It replaces the fixed, purely combinational 2-to-4 decoder with configurable address width and pipeline depth. It adds stall/flush control, optional zero-register masking, and an in-flight "busy" vector for hazard detection. It sits between writeback-address generation and the register file write port.

## Interface
Parameters:
- ADDR_W, default 5: address width; output one-hot width is 2**ADDR_W (legal 1..6).
- STAGES, default 2: pipeline depth, i.e. cycles from input capture to out_* (legal 1..4).
- MASK_ZERO, default 1: when 1, writes to ZERO_IDX are suppressed.
- ZERO_IDX, default 2**ADDR_W-1: index of the hard-wired zero register.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input address valid this cycle.
- in_en  input  1  write enable qualifier; 0 turns the input into a bubble.
- in_addr  input  ADDR_W  register index to decode.
- stall  input  1  holds every stage and ignores input.
- flush  input  1  kills all in-flight entries.
- out_valid  output  1  last stage holds a live write.
- out_addr  output  ADDR_W  address of the last-stage entry.
- out_onehot  output  2**ADDR_W  one-hot write enable; all zero when out_valid=0.
- busy  output  2**ADDR_W  OR of the one-hots of all valid stages 1..STAGES.

## Operation
- Stage k (1..STAGES) holds valid_k, addr_k and onehot_k. Decode happens at capture into stage 1: onehot_1 = 1 << in_addr.
- Capture condition: live = in_valid & in_en & ~(MASK_ZERO & in_addr==ZERO_IDX).
  - A non-live input enters stage 1 as a bubble: valid_1=0, onehot_1=0, addr_1=in_addr.
- Normal cycle (stall=0, flush=0): stage k+1 takes stage k; stage 1 takes the input.
- stall=1, flush=0: all stage registers hold; input is dropped, not queued.
- flush=1: all valid_k and onehot_k clear, regardless of stall.
  - Input in the same cycle is dropped; flush has priority over capture.
  - addr_k may hold any value.
- Outputs: out_valid=valid_STAGES, out_addr=addr_STAGES, out_onehot=onehot_STAGES.
- Invariant: onehot_k has exactly one bit set when valid_k=1, and is zero otherwise.
- busy is combinational from stage registers only, with no path from inputs. It is used by the hazard unit to detect pending writes.
- Reset (asserted at any time, including mid-operation): all valid_k=0, onehot_k=0, addr_k=0 immediately. Therefore out_valid=0, out_onehot=0, out_addr=0, busy=0.
- On reset_n deassertion, the first capture occurs on the next rising edge.

## Timing
- Latency: an input sampled on edge E appears on out_* after edge E+STAGES-1 (STAGES cycles of visibility delay counting the capture edge). With STAGES=1, outputs change right after the capture edge.
- Throughput: one write per cycle when stall=0.
- Stall cycles add 1 cycle of latency each to every in-flight entry. Outputs are stable throughout a stall.
- Flush takes effect at the next edge: out_valid=0 and busy=0 on the cycle after the flush edge, until new entries arrive.
- Duplicate addresses in flight are legal; busy shows a single bit for them.
- Simultaneous stall+flush behaves as flush.

## Test plan
All scenarios use ADDR_W=5, STAGES=2, MASK_ZERO=1 unless stated.
- **Sweep:** in_addr 0..30 back-to-back with valid=en=1 → out_onehot=1<<a two cycles later, one per cycle, out_addr matches. Addr 31 → out_valid=0, out_onehot=0.
- **Bubbles:** in_en=0 with addr 5 → no output. Then MASK_ZERO=0, addr 31 → out_onehot=32'h8000_0000.
- **Stall:** issue 3 then 7, stall for 2 cycles after the second → out holds 3 during the stall, and 7 emerges 2 cycles later than unstalled. Input presented during the stall is never seen.
- **Flush:** 4, 9 in flight plus flush with stall=1 in the same cycle → next cycle out_valid=0, busy=0, and addr 9 never appears.
- **Busy:** 2 and 2 back-to-back → busy=32'h4 while either is in flight, then returns to 0.
- **Reset:** reset_n low mid-stream → immediately all outputs 0. After release, first input appears two cycles later. Repeat with STAGES=1 and STAGES=4 for the latency check.
